mem_stage: RTL and testbench

- Memory-access stage sitting directly downstream of the ID/MEM intermediate register.
- Consumes the IR, PC, X (address or ALU result) and Y (store data) fields from that register.
- Performs loads and stores to data memory over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding.
- Presents a registered IR/PC/result bundle to the next pipeline register.

---
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads/stores over a req/ack handshake, stalls upstream while busy.
// Optional access timeout with error pulse is enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     OPW      = 4,
  parameter logic [OPW-1:0]  OP_LOAD  = OPW'(4'h4),
  parameter logic [OPW-1:0]  OP_STORE = OPW'(4'h5),
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] ir_in,
  input  logic [WIDTH-3:0] pc_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             stall_out,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             valid_out,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-3:0] pc_out,
  output logic [WIDTH-1:0] z_out,
  output logic             err_out
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e           state_q;
  logic             valid_out_q, req_q, we_q;
  logic [WIDTH-1:0] ir_out_q, z_out_q, ir_lat_q;
  logic [WIDTH-3:0] pc_out_q, pc_lat_q;
  // The dmem address/wdata registers double as the latched X and Y operands.
  logic [WIDTH-1:0] addr_q, wdata_q;

  logic [OPW-1:0] opcode;
  logic           is_load, is_store, is_mem, timeout_hit;

  assign opcode   = ir_in[WIDTH-1 -: OPW];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load || is_store;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  // Fires in the TIMEOUT-th WAIT cycle; an ack in that same cycle takes priority.
  assign timeout_hit = (state_q == StWait) && !dmem_ack && (cnt_q == CntW'(TIMEOUT - 1));
  assign err_out     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif

  // The held instruction retires on the ack (or timeout) edge, so upstream may advance then.
  always_comb begin
    stall_out = 1'b0;
    if (state_q == StIdle) stall_out = valid_in && is_mem;
    else                   stall_out = !(dmem_ack || timeout_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_out_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      ir_out_q    <= '0;
      pc_out_q    <= '0;
      z_out_q     <= '0;
      ir_lat_q    <= '0;
      pc_lat_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      valid_out_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (valid_in && is_mem) begin
            ir_lat_q <= ir_in;
            pc_lat_q <= pc_in;
            addr_q   <= x_in;
            wdata_q  <= y_in;
            we_q     <= is_store;
            req_q    <= 1'b1;
            state_q  <= StWait;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end else if (valid_in) begin
            ir_out_q    <= ir_in;
            pc_out_q    <= pc_in;
            z_out_q     <= x_in;
            valid_out_q <= 1'b1;
          end
        end
        StWait: begin
          if (dmem_ack) begin
            req_q       <= 1'b0;
            ir_out_q    <= ir_lat_q;
            pc_out_q    <= pc_lat_q;
            z_out_q     <= we_q ? addr_q : dmem_rdata;
            valid_out_q <= 1'b1;
            state_q     <= StIdle;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            req_q       <= 1'b0;
            ir_out_q    <= ir_lat_q;
            pc_out_q    <= pc_lat_q;
            z_out_q     <= '0;
            valid_out_q <= 1'b1;
            err_q       <= 1'b1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid_out  = valid_out_q;
  assign ir_out     = ir_out_q;
  assign pc_out     = pc_out_q;
  assign z_out      = z_out_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: driver, memory responder and output monitor
// run as separate processes against a behavioural memory model.
module tb_mem_stage;
  localparam int W = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic          clk, rst, valid_in, stall_out;
  logic [W-1:0]  ir_in, x_in, y_in, dmem_addr, dmem_wdata, dmem_rdata, ir_out, z_out;
  logic [W-3:0]  pc_in, pc_out;
  logic          dmem_req, dmem_we, dmem_ack, valid_out, err_out;

  mem_stage #(.WIDTH(W), .OPW(4), .OP_LOAD(4'h4), .OP_STORE(4'h5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ir_in(ir_in), .pc_in(pc_in), .x_in(x_in),
    .y_in(y_in), .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .valid_out(valid_out), .ir_out(ir_out), .pc_out(pc_out),
    .z_out(z_out), .err_out(err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] ir; logic [29:0] pc; logic [31:0] z; logic err;} out_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;

  out_t        exp_q[$];
  req_t        req_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem[8];
  logic [31:0] dev_mem[8];
  bit          resp_en = 1'b0;
  bit          mon_en = 1'b0;
  logic        force_ack = 1'b0;
  int          forced_delay = -1;
  bit          last_to = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after a chosen number of extra WAIT cycles.
  initial begin
    int   wcnt, dly;
    bit   busy;
    req_t cur;
    busy = 1'b0; wcnt = 0; dly = 0; cur = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (!resp_en) begin
        busy = 1'b0;
        dmem_ack = force_ack;
      end else if (!dmem_req) begin
        busy = 1'b0;
        dmem_ack = ($urandom_range(0, 3) == 0);  // stray acks must be ignored
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = 0;
          if (forced_delay >= 0) dly = forced_delay;
          else begin
`ifdef MEM_TIMEOUT_EN
            int r;
            r = int'($urandom_range(0, 5));
            dly = (r < 4) ? r : ((r == 4) ? TO - 1 : TO + 2);
`else
            dly = int'($urandom_range(0, 3));
`endif
          end
          last_to = (dly >= TO);
          if (req_q.size() == 0) begin
            bad++; total++;
            $display("FAIL unexpected_req: got request addr %h expected none", dmem_addr);
            cur = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata};
          end else cur = req_q.pop_front();
          chk("req_we", {31'b0, dmem_we}, {31'b0, cur.we});
          chk("req_addr", dmem_addr, cur.addr);
          if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
        end else begin
          chk("hold_addr", dmem_addr, cur.addr);
          chk("hold_we", {31'b0, dmem_we}, {31'b0, cur.we});
          if (cur.we) chk("hold_wdata", dmem_wdata, cur.wdata);
        end
        if (wcnt == dly) begin
          dmem_ack = 1'b1;
          if (dmem_we) dev_mem[dmem_addr[4:2]] = dmem_wdata;
          else dmem_rdata = dev_mem[dmem_addr[4:2]];
          busy = 1'b0;
        end else wcnt++;
      end
    end
  end

  // Output monitor: pops the scoreboard on valid_out, otherwise checks outputs hold.
  initial begin
    out_t held, e;
    logic r;
    held = '0;
    wait (mon_en);
    forever begin
      @(posedge clk); r = rst;
      @(negedge clk);
      if (r) begin
        held = '0;
        chk("valid_after_rst", {31'b0, valid_out}, 32'd0);
      end else if (valid_out) begin
        if (exp_q.size() == 0) begin
          bad++; total++;
          $display("FAIL unexpected_valid: got ir %h expected no output", ir_out);
        end else begin
          e = exp_q.pop_front();
          chk("ir_out", ir_out, e.ir);
          chk("pc_out", {2'b0, pc_out}, {2'b0, e.pc});
          chk("z_out", z_out, e.z);
          chk("err_out", {31'b0, err_out}, {31'b0, e.err});
          held = e;
        end
      end else begin
        chk("hold_ir", ir_out, held.ir);
        chk("hold_pc", {2'b0, pc_out}, {2'b0, held.pc});
        chk("hold_z", z_out, held.z);
        chk("err_idle", {31'b0, err_out}, 32'd0);
      end
    end
  end

  // Presents one instruction (entered and left just after a posedge) until upstream may advance.
  task automatic issue(input logic [31:0] ir, input logic [29:0] pc, input logic [31:0] x,
                       input logic [31:0] y, input int delay);
    bit   mem, st, done, first;
    int   n;
    out_t e;
    mem = (ir[31:28] == 4'h4) || (ir[31:28] == 4'h5);
    st  = (ir[31:28] == 4'h5);
    forced_delay = delay;
    valid_in = 1'b1; ir_in = ir; pc_in = pc; x_in = x; y_in = y;
    if (mem) req_q.push_back('{we: st, addr: x, wdata: y});
    n = 0; done = 1'b0; first = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (first) chk("stall_accept", {31'b0, stall_out}, {31'b0, mem});
      first = 1'b0;
      if (!stall_out) done = 1'b1;
      else if (++n > 60) begin
        bad++; total++;
        $display("FAIL stall_bound: got stall_out held %0d cycles expected release", n);
        valid_in = 1'b0;
        return;
      end
      @(posedge clk);
      if (done) begin
        e = '{ir: ir, pc: pc, z: x, err: 1'b0};
        if (mem && last_to) begin
          e.z = '0;
          e.err = 1'b1;
        end else if (mem && !st) e.z = ref_mem[x[4:2]];
        else if (mem) ref_mem[x[4:2]] = y;
        exp_q.push_back(e);
      end
      #1;
      if (!done) begin
        ir_in = $urandom; pc_in = 30'($urandom); x_in = $urandom; y_in = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    ir_in = $urandom; x_in = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 32'h1000_0000 + 32'(i * 17);
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 32'hDEAD_BEEF;
    dev_mem[0] = 32'hDEAD_BEEF;
    rst = 1'b1; valid_in = 1'b0; ir_in = '0; pc_in = '0; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_ir", ir_out, 32'd0);
    chk("rst_pc", {2'b0, pc_out}, 32'd0);
    chk("rst_z", z_out, 32'd0);
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_err", {31'b0, err_out}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);

    // Reset in the second WAIT cycle abandons the load; a later stray ack is ignored.
    @(posedge clk); #1;
    valid_in = 1'b1; ir_in = 32'h4000_0001; pc_in = 30'h55; x_in = 32'h100; y_in = 32'h0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    chk("wait_req", {31'b0, dmem_req}, 32'd1);
    chk("wait_addr", dmem_addr, 32'h100);
    chk("wait_stall", {31'b0, stall_out}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    chk("abort_req", {31'b0, dmem_req}, 32'd0);
    chk("abort_addr", dmem_addr, 32'd0);
    chk("abort_ir", ir_out, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_valid", {31'b0, valid_out}, 32'd0);
      chk("abort_req_idle", {31'b0, dmem_req}, 32'd0);
    end
    @(posedge clk); #1;
    force_ack = 1'b0;
    resp_en = 1'b1;

    issue(32'h1000_0000, 30'h10, 32'h0000_1234, 32'h0, -1);  // ALU op passthrough
    issue(32'h4000_0002, 30'h11, 32'h0000_0100, 32'h0, 2);   // load, ack in 3rd WAIT cycle
    issue(32'h5000_0003, 30'h12, 32'h0000_0200, 32'h0000_CAFE, 1);
    idle(2);
    issue(32'h4000_0004, 30'h13, 32'h0000_0100, 32'h0, 0);   // back-to-back load/store
    issue(32'h5000_0005, 30'h14, 32'h0000_0104, 32'h1234_5678, 0);
    issue(32'h4000_0006, 30'h15, 32'h0000_0104, 32'h0, 0);
`ifdef MEM_TIMEOUT_EN
    issue(32'h4000_0007, 30'h16, 32'h0000_0108, 32'h0, TO + 5);
`endif
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ir;
      int sel;
      sel = int'($urandom_range(0, 3));
      ir = $urandom;
      if (sel == 0) ir[31:28] = 4'h4;
      else if (sel == 1) ir[31:28] = 4'h5;
      issue(ir, 30'($urandom), $urandom, $urandom, -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(12);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
